// File: rtl/fixed_point_accumulator.sv
// Saturating fixed-point accumulator: sums N signed samples into a wider
// clamped accumulator and hands each block sum downstream over valid/ready.
module fixed_point_accumulator #(
  parameter int IN_I  = 5,
  parameter int IN_F  = 3,
  parameter int ACC_I = 8,
  parameter int ACC_F = 3,
  parameter int N     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_I+IN_F-1:0]   in_data,
  input  logic                   in_ovf,
  input  logic                   in_unf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_I+ACC_F-1:0] out_data,
  output logic                   out_sat,
  output logic                   out_err
);

  localparam int W_ACC = ACC_I + ACC_F;
  localparam int SHIFT = ACC_F - IN_F;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t                  state, state_next;
  logic signed [W_ACC-1:0] acc, aligned, acc_next;
  logic signed [W_ACC:0]   sum;
  logic [CW-1:0]           count;
  logic                    sat, err, sat_next, err_next, clamp;
  logic                    in_fire, last;

  assign in_fire = in_valid && in_ready;
  assign last    = (count == CW'(N - 1));

  // Align the sample to the accumulator's binary point, then add with one
  // guard bit so overflow is visible as a mismatch of the top two bits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    aligned  = W_ACC'($signed(in_data)) <<< SHIFT;
    sum      = (W_ACC+1)'(acc) + (W_ACC+1)'(aligned);
    clamp    = 1'b0;
    acc_next = sum[W_ACC-1:0];
    if (sum[W_ACC] != sum[W_ACC-1]) begin
      clamp    = 1'b1;
      acc_next = sum[W_ACC] ? ACC_MIN : ACC_MAX;
    end
    sat_next = sat | clamp;
    err_next = err | in_ovf | in_unf;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sat      <= 1'b0;
      err      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_err  <= 1'b0;
    end else if (in_fire) begin
      if (last) begin
        out_data <= acc_next;
        out_sat  <= sat_next;
        out_err  <= err_next;
        acc      <= '0;
        count    <= '0;
        sat      <= 1'b0;
        err      <= 1'b0;
      end else begin
        acc   <= acc_next;
        count <= count + 1'b1;
        sat   <= sat_next;
        err   <= err_next;
      end
    end
  end

endmodule
